// File: rtl/lcd_char_if.sv
// Character-cell link between the status display formatter and the LCD driver.
// The driver (master) presents a (line, column) address and a frame marker; the
// formatter (slave) answers combinationally with the character byte and can
// request that refresh pauses at the next frame boundary.
interface lcd_char_if;
  logic [7:0] char_data;
  logic       hold;
  logic       char_line;
  logic [3:0] char_col;
  logic       frame_start;

  modport master (
    output char_line,
    output char_col,
    output frame_start,
    input  char_data,
    input  hold
  );

  modport slave (
    input  char_line,
    input  char_col,
    input  frame_start,
    output char_data,
    output hold
  );
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780-compatible 16x2 LCD driver in 8-bit mode. After the power-on wait it
// runs the four-command init sequence, then refreshes the panel forever: one
// address command per line followed by sixteen character writes, each byte
// fetched from the formatter through the character-cell interface.
module lcd_char_driver #(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 4,
  parameter int T_PULSE = 16,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic        clk,
  input  logic        rst,
  lcd_char_if.master  cellIf,
  output logic        init_done_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o
);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR, FETCH, XFER} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  // Every wait loads (T-1) and counts down to zero.
  localparam logic [19:0] PWR_LOAD   = 20'(T_PWR - 1);
  localparam logic [19:0] SETUP_LOAD = 20'(T_SETUP - 1);
  localparam logic [19:0] PULSE_LOAD = 20'(T_PULSE - 1);
  localparam logic [19:0] CMD_LOAD   = 20'(T_CMD - 1);
  localparam logic [19:0] CLEAR_LOAD = 20'(T_CLEAR - 1);

  state_t      state_q;
  phase_t      phase_q;
  logic [19:0] cnt_q;
  logic [1:0]  initIdx_q;
  logic [7:0]  lcdData_q;
  logic        lcdRs_q;
  logic        lcdEn_q;
  logic        initDone_q;
  logic        frameStart_q;
  logic        charLine_q;
  logic [3:0]  charCol_q;

  logic [19:0] waitLoad_d;
  logic        cntZero_d;
  logic [1:0]  initIdxNext_d;
  logic [3:0]  charColNext_d;

  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Post-pulse wait length: only the clear command (third init step) needs the long wait.
  always_comb begin
    waitLoad_d    = CMD_LOAD;
    if (state_q == INIT && initIdx_q == 2'd2) waitLoad_d = CLEAR_LOAD;
    cntZero_d     = (cnt_q == 20'd0);
    initIdxNext_d = initIdx_q + 2'd1;
    charColNext_d = charCol_q + 4'd1;
  end

  // Main sequencer: power-on wait, init commands, frame refresh with per-byte setup/pulse/wait.
  // IDLE is entered with frame_start already armed when hold is low, so an uninterrupted
  // refresh spends exactly one cycle in IDLE with frame_start high during that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PWR_WAIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= PWR_LOAD;
      initIdx_q    <= 2'd0;
      lcdData_q    <= 8'h00;
      lcdRs_q      <= 1'b0;
      lcdEn_q      <= 1'b0;
      initDone_q   <= 1'b0;
      frameStart_q <= 1'b0;
      charLine_q   <= 1'b0;
      charCol_q    <= 4'd0;
    end else begin
      frameStart_q <= 1'b0;
      case (state_q)
        PWR_WAIT: begin
          if (cntZero_d) begin
            lcdData_q <= initCmd(2'd0);
            lcdRs_q   <= 1'b0;
            initIdx_q <= 2'd0;
            cnt_q     <= SETUP_LOAD;
            phase_q   <= PH_SETUP;
            state_q   <= INIT;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end

        IDLE: begin
          if (frameStart_q) begin
            lcdData_q  <= 8'h80;
            lcdRs_q    <= 1'b0;
            charLine_q <= 1'b0;
            charCol_q  <= 4'd0;
            cnt_q      <= SETUP_LOAD;
            phase_q    <= PH_SETUP;
            state_q    <= ADDR;
          end else if (!cellIf.hold) begin
            frameStart_q <= 1'b1;
          end
        end

        FETCH: begin
          lcdData_q <= cellIf.char_data;
          lcdRs_q   <= 1'b1;
          cnt_q     <= SETUP_LOAD;
          phase_q   <= PH_SETUP;
          state_q   <= XFER;
        end

        INIT, ADDR, XFER: begin
          if (!cntZero_d) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            case (phase_q)
              PH_SETUP: begin
                lcdEn_q <= 1'b1;
                cnt_q   <= PULSE_LOAD;
                phase_q <= PH_PULSE;
              end
              PH_PULSE: begin
                lcdEn_q <= 1'b0;
                cnt_q   <= waitLoad_d;
                phase_q <= PH_WAIT;
              end
              PH_WAIT: begin
                case (state_q)
                  INIT: begin
                    if (initIdx_q == 2'd3) begin
                      initDone_q   <= 1'b1;
                      frameStart_q <= !cellIf.hold;
                      state_q      <= IDLE;
                    end else begin
                      initIdx_q <= initIdxNext_d;
                      lcdData_q <= initCmd(initIdxNext_d);
                      lcdRs_q   <= 1'b0;
                      cnt_q     <= SETUP_LOAD;
                      phase_q   <= PH_SETUP;
                    end
                  end
                  ADDR: begin
                    state_q <= FETCH;
                  end
                  default: begin
                    if (charCol_q != 4'd15) begin
                      charCol_q <= charColNext_d;
                      state_q   <= FETCH;
                    end else if (!charLine_q) begin
                      charCol_q  <= 4'd0;
                      charLine_q <= 1'b1;
                      lcdData_q  <= 8'hC0;
                      lcdRs_q    <= 1'b0;
                      cnt_q      <= SETUP_LOAD;
                      phase_q    <= PH_SETUP;
                      state_q    <= ADDR;
                    end else begin
                      charCol_q    <= 4'd0;
                      charLine_q   <= 1'b0;
                      frameStart_q <= !cellIf.hold;
                      state_q      <= IDLE;
                    end
                  end
                endcase
              end
              default: begin
                phase_q <= PH_SETUP;
              end
            endcase
          end
        end

        default: begin
          state_q <= PWR_WAIT;
          cnt_q   <= PWR_LOAD;
        end
      endcase
    end
  end

  assign cellIf.char_line   = charLine_q;
  assign cellIf.char_col    = charCol_q;
  assign cellIf.frame_start = frameStart_q;
  assign init_done_o        = initDone_q;
  assign lcd_data_o         = lcdData_q;
  assign lcd_rs_o           = lcdRs_q;
  assign lcd_en_o           = lcdEn_q;
  assign lcd_rw_o           = 1'b0;
  assign lcd_on_o           = 1'b1;

endmodule
